// File: rtl/bp_me_bedrock_to_axil_master.sv
// BedRock mem_cmd -> single-beat AXI4-Lite master bridge.
// One transaction is in flight at a time. Every command returns exactly one
// BedRock response, and that response echoes the command header unchanged.
// Unsupported message types and misaligned accesses get an error response
// and generate no AXI traffic.
module bp_me_bedrock_to_axil_master #(
   parameter int paddr_width_p   = 40,
   parameter int payload_width_p = 32,
   parameter int data_width_p    = 64,
   localparam int header_width_lp = 4 + paddr_width_p + 3 + payload_width_p
) (
   input  logic                       clk_i,
   input  logic                       reset_i,

   input  logic [header_width_lp-1:0] mem_cmd_header_i,
   input  logic [data_width_p-1:0]    mem_cmd_data_i,
   input  logic                       mem_cmd_v_i,
   output logic                       mem_cmd_ready_and_o,

   output logic [header_width_lp-1:0] mem_resp_header_o,
   output logic [data_width_p-1:0]    mem_resp_data_o,
   output logic                       mem_resp_v_o,
   input  logic                       mem_resp_ready_and_i,

   output logic [paddr_width_p-1:0]   m_axil_awaddr_o,
   output logic [2:0]                 m_axil_awprot_o,
   output logic                       m_axil_awvalid_o,
   input  logic                       m_axil_awready_i,

   output logic [data_width_p-1:0]    m_axil_wdata_o,
   output logic [7:0]                 m_axil_wstrb_o,
   output logic                       m_axil_wvalid_o,
   input  logic                       m_axil_wready_i,

   input  logic [1:0]                 m_axil_bresp_i,
   input  logic                       m_axil_bvalid_i,
   output logic                       m_axil_bready_o,

   output logic [paddr_width_p-1:0]   m_axil_araddr_o,
   output logic [2:0]                 m_axil_arprot_o,
   output logic                       m_axil_arvalid_o,
   input  logic                       m_axil_arready_i,

   input  logic [data_width_p-1:0]    m_axil_rdata_i,
   input  logic [1:0]                 m_axil_rresp_i,
   input  logic                       m_axil_rvalid_i,
   output logic                       m_axil_rready_o,

   output logic                       error_o
);

   // A set bit in the command mask means the command carries data; a set bit
   // in the response mask means the response returns data.
   // Bit positions are the message types: rd=0, wr=1, uc_rd=2, uc_wr=3, pre=4, amo=5.
   localparam logic [15:0] cmd_payload_mask  = 16'b0000_0000_0010_1010;
   localparam logic [15:0] resp_payload_mask = 16'b0000_0000_0010_0101;

   typedef enum logic [2:0] {
      e_ready,
      e_write,
      e_bresp,
      e_read,
      e_rresp,
      e_err,
      e_resp
   } state_t;

   state_t                     state_reg, state_next;
   logic [header_width_lp-1:0] hdr_reg;
   logic [data_width_p-1:0]    cmd_data_reg;
   logic [data_width_p-1:0]    resp_data_reg, resp_data_next;
   logic                       aw_done_reg, aw_done_next;
   logic                       w_done_reg, w_done_next;

   // Fields of the incoming command. Only these fields pick the next state.
   logic [3:0] cmd_type;
   logic [6:0] cmd_addr_lo;
   logic [2:0] cmd_size;
   logic       cmd_aligned;
   logic       cmd_write_class;
   logic       cmd_read_class;
   logic       cmd_hs;

   assign cmd_type        = mem_cmd_header_i[3:0];
   assign cmd_addr_lo     = mem_cmd_header_i[4 +: 7];
   assign cmd_size        = mem_cmd_header_i[4+paddr_width_p +: 3];
   // The shift gives zero when size is 7, so subtracting 1 still builds the 128-byte mask.
   assign cmd_aligned     = (cmd_addr_lo & ((7'd1 << cmd_size) - 7'd1)) == 7'd0;
   assign cmd_write_class = cmd_payload_mask[cmd_type];
   assign cmd_read_class  = resp_payload_mask[cmd_type] & ~cmd_payload_mask[cmd_type];
   assign cmd_hs          = mem_cmd_v_i & mem_cmd_ready_and_o;

   // Fields of the registered command. These drive the AXI payloads.
   logic [paddr_width_p-1:0] r_addr;
   logic [2:0]               r_size;
   logic [2:0]               r_off;
   logic [1:0]               r_lg;
   logic [3:0]               r_nbytes;
   logic [2:0]               lane_mask;

   assign r_addr    = hdr_reg[4 +: paddr_width_p];
   assign r_size    = hdr_reg[4+paddr_width_p +: 3];
   assign r_off     = r_addr[2:0];
   // A beat is 8 bytes, so any size above 8 bytes is capped at one full beat.
   assign r_lg      = (r_size > 3'd3) ? 2'd3 : r_size[1:0];
   assign r_nbytes  = 4'd1 << r_lg;
   assign lane_mask = 3'(r_nbytes - 4'd1);

   logic [7:0]              wstrb_lanes;
   logic [data_width_p-1:0] wdata_rep;
   logic [data_width_p-1:0] rdata_shift;
   logic [data_width_p-1:0] rdata_rep;

   assign rdata_shift = m_axil_rdata_i >> {r_off, 3'b000};

   // Each byte lane has its own strobe. Lane gi of a replicated word takes
   // source byte (gi mod access size).
   for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      localparam logic [3:0] lane = 4'(gi);
      logic [2:0] src;
      assign src             = lane[2:0] & lane_mask;
      assign wstrb_lanes[gi] = (lane >= {1'b0, r_off}) && (lane < ({1'b0, r_off} + r_nbytes));
      assign wdata_rep[gi*8 +: 8] = cmd_data_reg[{src, 3'b000} +: 8];
      assign rdata_rep[gi*8 +: 8] = rdata_shift[{src, 3'b000} +: 8];
   end

   assign m_axil_awaddr_o   = {r_addr[paddr_width_p-1:3], 3'b000};
   assign m_axil_araddr_o   = {r_addr[paddr_width_p-1:3], 3'b000};
   assign m_axil_awprot_o   = 3'b000;
   assign m_axil_arprot_o   = 3'b000;
   assign m_axil_wdata_o    = wdata_rep;
   assign m_axil_wstrb_o    = (state_reg == e_write) ? wstrb_lanes : 8'h00;
   assign mem_resp_header_o = hdr_reg;
   assign mem_resp_data_o   = resp_data_reg;

   // State, handshake flags and response data are cleared by reset and
   // updated every cycle.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_reg     <= e_ready;
         aw_done_reg   <= 1'b0;
         w_done_reg    <= 1'b0;
         resp_data_reg <= '0;
      end else begin
         state_reg     <= state_next;
         aw_done_reg   <= aw_done_next;
         w_done_reg    <= w_done_next;
         resp_data_reg <= resp_data_next;
      end
   end

   // Header and data are captured when a command is accepted and held until
   // the next command.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         hdr_reg      <= '0;
         cmd_data_reg <= '0;
      end else if (cmd_hs) begin
         hdr_reg      <= mem_cmd_header_i;
         cmd_data_reg <= mem_cmd_data_i;
      end
   end

   // Next state, handshake bookkeeping and all valid, ready and error outputs.
   always_comb begin
      state_next          = state_reg;
      aw_done_next        = aw_done_reg;
      w_done_next         = w_done_reg;
      resp_data_next      = resp_data_reg;
      mem_cmd_ready_and_o = 1'b0;
      mem_resp_v_o        = 1'b0;
      m_axil_awvalid_o    = 1'b0;
      m_axil_wvalid_o     = 1'b0;
      m_axil_bready_o     = 1'b0;
      m_axil_arvalid_o    = 1'b0;
      m_axil_rready_o     = 1'b0;
      error_o             = 1'b0;

      case (state_reg)
         e_ready: begin
            // Ready is held low while reset is asserted, even though the state is already e_ready.
            mem_cmd_ready_and_o = ~reset_i;
            aw_done_next        = 1'b0;
            w_done_next         = 1'b0;
            if (mem_cmd_v_i && !reset_i) begin
               resp_data_next = '0;
               if (cmd_type > 4'd3 || !cmd_aligned)
                  state_next = e_err;
               else if (cmd_write_class)
                  state_next = e_write;
               else if (cmd_read_class)
                  state_next = e_read;
               else
                  state_next = e_err;
            end
         end
         e_write: begin
            m_axil_awvalid_o = ~aw_done_reg;
            m_axil_wvalid_o  = ~w_done_reg;
            if (m_axil_awvalid_o && m_axil_awready_i) aw_done_next = 1'b1;
            if (m_axil_wvalid_o && m_axil_wready_i)   w_done_next  = 1'b1;
            if (aw_done_next && w_done_next) state_next = e_bresp;
         end
         e_bresp: begin
            m_axil_bready_o = 1'b1;
            if (m_axil_bvalid_i) begin
               error_o        = (m_axil_bresp_i != 2'b00);
               resp_data_next = '0;
               state_next     = e_resp;
            end
         end
         e_read: begin
            m_axil_arvalid_o = 1'b1;
            if (m_axil_arready_i) state_next = e_rresp;
         end
         e_rresp: begin
            m_axil_rready_o = 1'b1;
            if (m_axil_rvalid_i) begin
               error_o        = (m_axil_rresp_i != 2'b00);
               resp_data_next = rdata_rep;
               state_next     = e_resp;
            end
         end
         e_err: begin
            error_o        = 1'b1;
            resp_data_next = '0;
            state_next     = e_resp;
         end
         e_resp: begin
            mem_resp_v_o = 1'b1;
            if (mem_resp_ready_and_i) state_next = e_ready;
         end
         default: state_next = e_ready;
      endcase
   end

endmodule

// File: tb/tb_bp_me_bedrock_to_axil_master.sv
// Directed bench for bp_me_bedrock_to_axil_master. The bench plays the AXI4-Lite
// slave by hand and checks each transaction against hand-computed values.
module tb_bp_me_bedrock_to_axil_master;

   localparam int P  = 40;
   localparam int HW = 4 + P + 3 + 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [HW-1:0] cmd_hdr;
   logic [63:0]   cmd_data;
   logic          cmd_v, cmd_ready;
   logic [HW-1:0] resp_hdr;
   logic [63:0]   resp_data;
   logic          resp_v, resp_ready;
   logic [P-1:0]  awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic          awvalid, awready, wvalid, wready;
   logic [63:0]   wdata, rdata;
   logic [7:0]    wstrb;
   logic [1:0]    bresp, rresp;
   logic          bvalid, bready, arvalid, arready, rvalid, rready;
   logic          error;

   int vecs = 0;
   int miss = 0;
   int err_cnt = 0;
   int axi_v_cnt = 0;
   int resp_cnt = 0;

   always #5 clk = ~clk;

   bp_me_bedrock_to_axil_master dut (
      .clk_i(clk), .reset_i(reset),
      .mem_cmd_header_i(cmd_hdr), .mem_cmd_data_i(cmd_data),
      .mem_cmd_v_i(cmd_v), .mem_cmd_ready_and_o(cmd_ready),
      .mem_resp_header_o(resp_hdr), .mem_resp_data_o(resp_data),
      .mem_resp_v_o(resp_v), .mem_resp_ready_and_i(resp_ready),
      .m_axil_awaddr_o(awaddr), .m_axil_awprot_o(awprot),
      .m_axil_awvalid_o(awvalid), .m_axil_awready_i(awready),
      .m_axil_wdata_o(wdata), .m_axil_wstrb_o(wstrb),
      .m_axil_wvalid_o(wvalid), .m_axil_wready_i(wready),
      .m_axil_bresp_i(bresp), .m_axil_bvalid_i(bvalid), .m_axil_bready_o(bready),
      .m_axil_araddr_o(araddr), .m_axil_arprot_o(arprot),
      .m_axil_arvalid_o(arvalid), .m_axil_arready_i(arready),
      .m_axil_rdata_i(rdata), .m_axil_rresp_i(rresp),
      .m_axil_rvalid_i(rvalid), .m_axil_rready_o(rready),
      .error_o(error)
   );

   // Count error pulses, AXI request valids and completed responses at each active clock edge.
   always @(posedge clk) begin
      if (error) err_cnt++;
      if (awvalid || wvalid || arvalid) axi_v_cnt++;
      if (resp_v && resp_ready) resp_cnt++;
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vecs++;
      if (got !== exp) begin
         miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [HW-1:0] mk(input logic [3:0] t, input logic [P-1:0] a,
                                        input logic [2:0] s, input logic [31:0] p);
      return {p, s, a, t};
   endfunction

   task automatic issue(input string tag, input logic [HW-1:0] h, input logic [63:0] d);
      cmd_hdr  = h;
      cmd_data = d;
      cmd_v    = 1'b1;
      #1;
      chk({tag, " cmd_ready"}, 128'(cmd_ready), 128'd1);
      tick();
      cmd_v = 1'b0;
   endtask

   task automatic wait_resp(input string tag, input logic [HW-1:0] eh, input logic [63:0] ed);
      int n = 0;
      while (!resp_v && n < 20) begin
         tick();
         n++;
      end
      chk({tag, " resp_v"}, 128'(resp_v), 128'd1);
      chk({tag, " resp_hdr"}, 128'(resp_hdr), 128'(eh));
      chk({tag, " resp_data"}, 128'(resp_data), 128'(ed));
      $display("txn %s: hdr=%h data=%h wait=%0d", tag, resp_hdr, resp_data, n);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk({tag, " ready_after"}, 128'(cmd_ready), 128'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [HW-1:0] h;
      int e0, v0, r0;

      reset = 1'b1; cmd_v = 0; cmd_hdr = '0; cmd_data = '0; resp_ready = 0;
      awready = 0; wready = 0; bresp = 0; bvalid = 0; arready = 0;
      rdata = '0; rresp = 0; rvalid = 0;
      repeat (3) @(negedge clk);
      chk("rst cmd_ready", 128'(cmd_ready), 128'd0);
      chk("rst resp_v", 128'(resp_v), 128'd0);
      chk("rst valids", 128'({awvalid, wvalid, arvalid, bready, rready, error}), 128'd0);
      chk("rst wstrb", 128'(wstrb), 128'd0);
      chk("rst hdr", 128'(resp_hdr), 128'd0);
      reset = 1'b0;
      #1;
      chk("post-rst cmd_ready", 128'(cmd_ready), 128'd1);
      @(negedge clk);

      // uc_wr, 4 bytes at offset 4; AW and W accepted in the same cycle.
      e0 = err_cnt;
      h = mk(4'd3, 40'h00_8000_0004, 3'd2, 32'hCAFE_0001);
      issue("t1", h, 64'h0000_0000_DEAD_BEEF);
      chk("t1 awvalid", 128'(awvalid), 128'd1);
      chk("t1 wvalid", 128'(wvalid), 128'd1);
      chk("t1 awaddr", 128'(awaddr), 128'h80000000);
      chk("t1 wstrb", 128'(wstrb), 128'hF0);
      chk("t1 wdata", 128'(wdata), 128'hDEADBEEF_DEADBEEF);
      chk("t1 awprot", 128'(awprot), 128'd0);
      awready = 1; wready = 1;
      tick();
      awready = 0; wready = 0;
      chk("t1 aw/w dropped", 128'({awvalid, wvalid}), 128'd0);
      chk("t1 bready", 128'(bready), 128'd1);
      bvalid = 1; bresp = 0;
      tick();
      bvalid = 0;
      wait_resp("t1", h, 64'd0);
      chk("t1 no error", 128'(err_cnt - e0), 128'd0);

      // uc_rd, 2 bytes at offset 6.
      h = mk(4'd2, 40'h00_8000_0006, 3'd1, 32'h0000_0002);
      issue("t2", h, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t2 arvalid", 128'(arvalid), 128'd1);
      chk("t2 araddr", 128'(araddr), 128'h80000000);
      chk("t2 arprot", 128'(arprot), 128'd0);
      chk("t2 no awvalid", 128'(awvalid), 128'd0);
      arready = 1;
      tick();
      arready = 0;
      chk("t2 rready", 128'(rready), 128'd1);
      chk("t2 arvalid dropped", 128'(arvalid), 128'd0);
      rvalid = 1; rresp = 0; rdata = 64'h1234_5678_9ABC_DEF0;
      tick();
      rvalid = 0;
      wait_resp("t2", h, 64'h1234_1234_1234_1234);

      // wr, 8 bytes; W completes first and AW follows three cycles later.
      r0 = resp_cnt;
      h = mk(4'd1, 40'h00_8000_0010, 3'd3, 32'h0000_0003);
      issue("t3", h, 64'h0123_4567_89AB_CDEF);
      chk("t3 wstrb", 128'(wstrb), 128'hFF);
      chk("t3 wdata", 128'(wdata), 128'h0123_4567_89AB_CDEF);
      chk("t3 awaddr", 128'(awaddr), 128'h80000010);
      wready = 1;
      tick();
      wready = 0;
      for (int i = 0; i < 3; i++) begin
         chk("t3 awvalid held", 128'(awvalid), 128'd1);
         chk("t3 wvalid dropped", 128'(wvalid), 128'd0);
         chk("t3 no bready yet", 128'(bready), 128'd0);
         if (i == 2) awready = 1;
         tick();
      end
      awready = 0;
      chk("t3 awvalid dropped", 128'(awvalid), 128'd0);
      chk("t3 bready", 128'(bready), 128'd1);
      bvalid = 1; bresp = 0;
      tick();
      bvalid = 0;
      wait_resp("t3", h, 64'd0);
      tick();
      tick();
      chk("t3 one response", 128'(resp_cnt - r0), 128'd1);
      chk("t3 resp_v idle", 128'(resp_v), 128'd0);

      // An amo command, then a misaligned uc_rd: both are answered with error responses and no AXI traffic.
      e0 = err_cnt; v0 = axi_v_cnt;
      h = mk(4'd5, 40'h00_8000_0000, 3'd3, 32'h0000_0004);
      issue("t4a", h, 64'h5555_AAAA_5555_AAAA);
      wait_resp("t4a", h, 64'd0);
      h = mk(4'd2, 40'h00_8000_0004, 3'd3, 32'h0000_0005);
      issue("t4b", h, 64'h7777_7777_7777_7777);
      wait_resp("t4b", h, 64'd0);
      chk("t4 no axi valids", 128'(axi_v_cnt - v0), 128'd0);
      chk("t4 two errors", 128'(err_cnt - e0), 128'd2);

      // rd with an error response (rresp=2); the response is then held through backpressure.
      e0 = err_cnt;
      h = mk(4'd0, 40'h00_8000_0008, 3'd3, 32'h0000_0006);
      issue("t5", h, 64'd0);
      chk("t5 arvalid", 128'(arvalid), 128'd1);
      arready = 1;
      tick();
      arready = 0;
      rvalid = 1; rresp = 2; rdata = 64'hA5A5_0000_FFFF_1111;
      #1;
      chk("t5 error pulse", 128'(error), 128'd1);
      tick();
      rvalid = 0; rresp = 0;
      for (int i = 0; i < 5; i++) begin
         chk("t5 hold resp_v", 128'(resp_v), 128'd1);
         chk("t5 hold hdr", 128'(resp_hdr), 128'(h));
         chk("t5 hold data", 128'(resp_data), 128'hA5A5_0000_FFFF_1111);
         chk("t5 cmd_ready low", 128'(cmd_ready), 128'd0);
         tick();
      end
      wait_resp("t5", h, 64'hA5A5_0000_FFFF_1111);
      chk("t5 one error", 128'(err_cnt - e0), 128'd1);

      // Reset asserted asynchronously while awvalid is high.
      r0 = resp_cnt;
      h = mk(4'd3, 40'h00_8000_0000, 3'd3, 32'h0000_0007);
      issue("t6", h, 64'h1111_2222_3333_4444);
      chk("t6 awvalid", 128'(awvalid), 128'd1);
      #2 reset = 1'b1;
      #1;
      chk("t6 async awvalid drop", 128'({awvalid, wvalid}), 128'd0);
      chk("t6 cmd_ready in reset", 128'(cmd_ready), 128'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("t6 cmd_ready after", 128'(cmd_ready), 128'd1);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("t6 no resp", 128'(resp_v), 128'd0);
         tick();
      end
      chk("t6 no axi", 128'({awvalid, wvalid, arvalid}), 128'd0);
      chk("t6 resp count", 128'(resp_cnt - r0), 128'd0);
      $display("txn t6: reset during write, no response");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule

// File: doc/bp_me_bedrock_to_axil_master.md
Name: bp_me_bedrock_to_axil_master

Overview:
- Converts BedRock memory commands into single-beat AXI4-Lite master transactions and returns BedRock memory responses.
- Sits downstream of the CCE/LCE mem_cmd network and drives an AXI4-Lite slave, such as a peripheral or a host bridge.
- Uses the ME payload masks to decide which commands carry data and which responses return data.
- Holds one transaction in flight at a time.

Parameters:
- paddr_width_p, 40, physical address width.
- payload_width_p, 32, opaque BedRock payload width, echoed unchanged.
- data_width_p, 64, BedRock and AXI data width; fixed at 64.
- header_width_lp, 4+paddr_width_p+3+payload_width_p, derived header width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- mem_cmd_header_i  in  header_width_lp  header fields:
  - [3:0] msg_type
  - [4+:paddr] addr
  - [4+paddr+:3] size
  - upper bits: payload
- mem_cmd_data_i  in  64  command data.
- mem_cmd_v_i  in  1  command valid.
- mem_cmd_ready_and_o  out  1  command ready.
- mem_resp_header_o  out  header_width_lp  response header.
- mem_resp_data_o  out  64  response data.
- mem_resp_v_o  out  1  response valid.
- mem_resp_ready_and_i  in  1  response ready.
- m_axil_awaddr_o out paddr; m_axil_awprot_o out 3; m_axil_awvalid_o out 1; m_axil_awready_i in 1.
- m_axil_wdata_o out 64; m_axil_wstrb_o out 8; m_axil_wvalid_o out 1; m_axil_wready_i in 1.
- m_axil_bresp_i in 2; m_axil_bvalid_i in 1; m_axil_bready_o out 1.
- m_axil_araddr_o out paddr; m_axil_arprot_o out 3; m_axil_arvalid_o out 1; m_axil_arready_i in 1.
- m_axil_rdata_i in 64; m_axil_rresp_i in 2; m_axil_rvalid_i in 1; m_axil_rready_o out 1.
- error_o  out  1  one-cycle pulse on any error.

Behaviour:
- Reset:
  - reset_i is asserted asynchronously and released on a clk_i edge.
  - While in reset, state = e_ready, the header/data registers are cleared and all outputs are 0, except mem_cmd_ready_and_o = 0.
  - mem_cmd_ready_and_o rises in the first cycle after reset deassertion.
- Message type encodings: rd=0, wr=1, uc_rd=2, uc_wr=3, pre=4, amo=5.
  - Write-class: mem_cmd_payload_mask bit is set (wr, uc_wr, amo).
  - Read-class: mem_resp_payload_mask bit is set and the type is not write-class (rd, uc_rd).
- e_ready:
  - mem_cmd_ready_and_o = 1.
  - A command is accepted on v&ready; the header and data are registered.
  - Next state:
    - e_err if msg_type is not in {0,1,2,3}, or addr is not aligned to 2^size bytes.
    - e_write for write-class commands.
    - e_read for read-class commands.
- e_write:
  - awvalid and wvalid are asserted from the next cycle; awprot = 0.
  - awaddr = addr with bits [2:0] cleared.
  - wdata = command data low 2^size bytes, replicated across 64 bits.
  - wstrb = ((1<<2^size)-1) << addr[2:0].
  - AW and W handshakes complete independently, in either order or the same cycle. Each valid drops in the cycle after its own handshake.
  - Once both have completed, go to e_bresp.
- e_bresp: bready = 1. On bvalid, error_o pulses if bresp != 0. Response data = 0. Go to e_resp.
- e_read: arvalid = 1, araddr = addr with [2:0] cleared. On arready, go to e_rresp.
- e_rresp:
  - rready = 1.
  - On rvalid, response data = (rdata >> 8*addr[2:0]) low 2^size bytes, replicated to 64 bits.
  - error_o pulses if rresp != 0. Go to e_resp.
- e_err: error_o pulses for one cycle, response data = 0, no AXI activity. Go to e_resp.
- e_resp:
  - mem_resp_v_o = 1; the header is echoed unchanged from the command.
  - Header and data stay stable until ready. On v&ready, go to e_ready; a new command can be accepted the following cycle.
- Latency: minimum 4 cycles from command accept to response valid, with zero-wait AXI (accept, A, B/R, resp).
- A valid on either interface, once raised, is held stable until its handshake (AXI rule and BedRock ready&valid).
- Reset mid-transaction:
  - All valids and readies drop immediately and the state returns to e_ready.
  - In-flight AXI responses are not tracked; the slave is reset in the same domain.
- Only one transaction is outstanding at a time; mem_cmd_ready_and_o = 0 outside e_ready.

Test Plan:
- uc_wr, size=2, addr=0x8000_0004, data=0xDEADBEEF; AW and W ready in the same cycle; bresp=0 → awaddr=0x8000_0000, wstrb=0xF0, wdata=0xDEADBEEF_DEADBEEF. Response has header identical to the command, data=0, error_o=0.
- uc_rd, size=1, addr=0x8000_0006; rdata=0x1234_5678_9ABC_DEF0 → response data=0x1234_1234_1234_1234.
- wr with awready delayed 3 cycles and wready immediate → W completes first; wvalid drops while awvalid stays held. B arrives only after both complete; exactly one response is returned.
- amo command, then a misaligned uc_rd (size=3, addr=0x...4) → no AXI valids ever asserted. Two responses, each with data=0, and one error_o pulse for each.
- rd with rresp=2 → error_o pulses once; the response is still returned with rdata-derived data. Holding mem_resp_ready_and_i=0 for 5 cycles keeps header and data stable, and mem_cmd_ready_and_o stays 0.
- Assert reset_i asynchronously while in e_write with awvalid high → awvalid drops before the next clock edge. After release, mem_cmd_ready_and_o=1 and no response is emitted.
